// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage hazard query and pipeline-control bundle for hazard_scoreboard
interface hazard_scoreboard_if #(
    parameter int NUM_RD     = 2,
    parameter int REG_AW     = 5,
    parameter int FWD_STAGES = 3,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
);
    logic                     id_valid;
    logic [NUM_RD-1:0]        id_rd_en;
    logic [NUM_RD*REG_AW-1:0] id_rs;
    logic                     id_we;
    logic [REG_AW-1:0]        id_wr;
    logic [SEL_W-1:0]         id_lat;
    logic                     pipe_hold;
    logic                     flush;
    logic [NUM_RD*SEL_W-1:0]  fwd_sel;
    logic                     stall_data;
    modport master (
        output id_valid, id_rd_en, id_rs, id_we, id_wr, id_lat, pipe_hold, flush,
        input  fwd_sel, stall_data
    );
    modport slave (
        input  id_valid, id_rd_en, id_rs, id_we, id_wr, id_lat, pipe_hold, flush,
        output fwd_sel, stall_data
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tag shift register giving per-port forward select and data stall.
// Optional HAZ_PERF_CNT_EN adds saturating stall/forward performance counters.
module hazard_scoreboard #(
    parameter int  NUM_RD     = 2,
    parameter int  REG_AW     = 5,
    parameter int  FWD_STAGES = 3,
    localparam int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input logic                cpu_clk,
    input logic                cpu_rst_n,
    hazard_scoreboard_if.slave hs
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_fwd_cnt
`endif
);
    localparam logic [SEL_W-1:0] MAX_CNT = SEL_W'(FWD_STAGES - 1);
    logic                    v   [1:FWD_STAGES];
    logic                    we  [1:FWD_STAGES];
    logic [REG_AW-1:0]       wr  [1:FWD_STAGES];
    logic [SEL_W-1:0]        cnt [1:FWD_STAGES];
    logic [NUM_RD*SEL_W-1:0] sel_c;
    logic [NUM_RD-1:0]       busy_c;
    logic [SEL_W-1:0]        lat_c;
    logic                    stall_c;
    // Scan oldest to youngest so the youngest producer's select and readiness win.
    always_comb begin
        sel_c  = '0;
        busy_c = '0;
        for (int p = 0; p < NUM_RD; p++)
            for (int k = FWD_STAGES; k >= 1; k--)
                if (hs.id_rd_en[p] && hs.id_rs[p*REG_AW +: REG_AW] != '0 && v[k] && we[k] &&
                    wr[k] == hs.id_rs[p*REG_AW +: REG_AW]) begin
                    sel_c[p*SEL_W +: SEL_W] = SEL_W'(k);
                    busy_c[p]               = cnt[k] != '0;
                end
    end
    assign lat_c         = hs.id_lat > MAX_CNT ? MAX_CNT : hs.id_lat;
    assign stall_c       = cpu_rst_n && hs.id_valid && |busy_c;
    assign hs.stall_data = stall_c;
    assign hs.fwd_sel    = cpu_rst_n ? sel_c : '0;
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            for (int k = 1; k <= FWD_STAGES; k++) begin
                v[k]   <= 1'b0;
                we[k]  <= 1'b0;
                cnt[k] <= '0;
            end
        end else if (!hs.pipe_hold) begin
            for (int k = FWD_STAGES; k >= 2; k--) begin
                v[k]   <= v[k-1];
                we[k]  <= we[k-1];
                wr[k]  <= wr[k-1];
                cnt[k] <= cnt[k-1] == '0 ? '0 : cnt[k-1] - 1'b1;
            end
            v[1]   <= hs.id_valid && !stall_c && !hs.flush;
            we[1]  <= hs.id_we;
            wr[1]  <= hs.id_wr;
            cnt[1] <= lat_c;
        end
    end
`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            perf_stall_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else begin
            if (stall_c && !hs.pipe_hold && ~&perf_stall_cnt)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (hs.id_valid && !stall_c && !hs.pipe_hold && |sel_c && ~&perf_fwd_cnt)
                perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and random stimulus against an issue-history reference model
module tb_hazard_scoreboard;
    localparam int NUM_RD = 2;
    localparam int REG_AW = 5;
    localparam int FWD    = 3;
    logic cpu_clk   = 1'b0;
    logic cpu_rst_n = 1'b0;
    hazard_scoreboard_if #(.NUM_RD(NUM_RD), .REG_AW(REG_AW), .FWD_STAGES(FWD)) hs ();
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_fwd_cnt;
    int ps_m = 0, pf_m = 0;
    hazard_scoreboard #(.NUM_RD(NUM_RD), .REG_AW(REG_AW), .FWD_STAGES(FWD)) dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .hs(hs),
        .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt));
`else
    hazard_scoreboard #(.NUM_RD(NUM_RD), .REG_AW(REG_AW), .FWD_STAGES(FWD)) dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n), .hs(hs));
`endif
    always #5 cpu_clk = ~cpu_clk;
    // hist[k] is the instruction issued k+1 advances ago; lat is its clamped latency at issue.
    typedef struct {logic v; logic we; logic [4:0] wr; int lat;} ent_t;
    typedef struct {logic [3:0] sel; logic stall; int cyc;} exp_t;
    ent_t hist[$];
    exp_t exp_q[$];
    exp_t me;
    int errors = 0, checks = 0, cyc = 0;
    logic last_stall = 1'b0;
    task automatic step(input logic v, input logic [1:0] en, input logic [4:0] rs0, input logic [4:0] rs1,
                        input logic we, input logic [4:0] wr, input int lat,
                        input logic hold, input logic fl, input logic rst_n);
        exp_t e;
        ent_t n;
        logic busy;
        logic [4:0] rs;
        @(posedge cpu_clk);
        #1;
        hs.id_valid = v; hs.id_rd_en = en; hs.id_rs = {rs1, rs0};
        hs.id_we = we; hs.id_wr = wr; hs.id_lat = 2'(lat);
        hs.pipe_hold = hold; hs.flush = fl; cpu_rst_n = rst_n;
        e.sel = '0; busy = 1'b0; e.cyc = cyc++;
        for (int p = 0; p < NUM_RD; p++) begin
            rs = p == 0 ? rs0 : rs1;
            for (int k = 0; k < FWD; k++)
                if (en[p] && rs != 0 && hist[k].v && hist[k].we && hist[k].wr == rs) begin
                    e.sel[p*2 +: 2] = 2'(k + 1);
                    if (hist[k].lat > k) busy = 1'b1;
                    break;
                end
        end
        e.stall = rst_n && v && busy;
        if (!rst_n) e.sel = '0;
        exp_q.push_back(e);
        last_stall = e.stall;
`ifdef HAZ_PERF_CNT_EN
        if (!rst_n) begin ps_m = 0; pf_m = 0; end
        else begin
            if (e.stall && !hold) ps_m++;
            if (v && !e.stall && !hold && e.sel != 0) pf_m++;
        end
`endif
        if (!rst_n) begin
            hist.delete();
            for (int k = 0; k < FWD; k++) hist.push_back('{1'b0, 1'b0, 5'd0, 0});
        end else if (!hold) begin
            n.v = v && !e.stall && !fl; n.we = we; n.wr = wr; n.lat = lat > FWD - 1 ? FWD - 1 : lat;
            hist.push_front(n);
            void'(hist.pop_back());
        end
    endtask
    initial forever begin
        @(negedge cpu_clk);
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            checks += 2;
            if (hs.fwd_sel !== me.sel) begin
                errors++;
                $display("FAIL fwd_sel cyc=%0d got=%h exp=%h", me.cyc, hs.fwd_sel, me.sel);
            end
            if (hs.stall_data !== me.stall) begin
                errors++;
                $display("FAIL stall_data cyc=%0d got=%b exp=%b", me.cyc, hs.stall_data, me.stall);
            end
        end
    end
    logic r_v, r_we, r_hold, r_fl, r_rst;
    logic [1:0] r_en;
    logic [4:0] r_rs0, r_rs1, r_wr;
    int r_lat;
    initial begin
        hs.id_valid = 0; hs.id_rd_en = 0; hs.id_rs = 0; hs.id_we = 0;
        hs.id_wr = 0; hs.id_lat = 0; hs.pipe_hold = 0; hs.flush = 0;
        for (int k = 0; k < FWD; k++) hist.push_back('{1'b0, 1'b0, 5'd0, 0});
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        // ALU chain
        step(1, 2'b00, 0, 0, 1, 5, 0, 0, 0, 1);
        step(1, 2'b01, 5, 0, 0, 0, 0, 0, 0, 1);
        step(1, 2'b10, 0, 5, 0, 0, 0, 0, 0, 1);
        // load-use
        step(1, 2'b00, 0, 0, 1, 6, 1, 0, 0, 1);
        step(1, 2'b01, 6, 0, 0, 0, 0, 0, 0, 1);
        step(1, 2'b01, 6, 0, 0, 0, 0, 0, 0, 1);
        // x0 and store
        step(1, 2'b00, 0, 0, 1, 0, 0, 0, 0, 1);
        step(1, 2'b11, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 2'b00, 0, 0, 0, 7, 0, 0, 0, 1);
        step(1, 2'b01, 7, 0, 0, 0, 0, 0, 0, 1);
        // youngest wins, then younger non-ready load
        step(1, 2'b00, 0, 0, 1, 7, 0, 0, 0, 1);
        step(1, 2'b00, 0, 0, 0, 1, 0, 0, 0, 1);
        step(1, 2'b00, 0, 0, 1, 7, 0, 0, 0, 1);
        step(1, 2'b01, 7, 0, 0, 0, 0, 0, 0, 1);
        step(1, 2'b00, 0, 0, 1, 7, 0, 0, 0, 1);
        step(1, 2'b00, 0, 0, 0, 1, 0, 0, 0, 1);
        step(1, 2'b00, 0, 0, 1, 7, 1, 0, 0, 1);
        step(1, 2'b01, 7, 0, 0, 0, 0, 0, 0, 1);
        step(1, 2'b01, 7, 0, 0, 0, 0, 0, 0, 1);
        // hold with a pending load
        step(1, 2'b00, 0, 0, 1, 8, 1, 0, 0, 1);
        repeat (3) step(1, 2'b01, 8, 0, 0, 0, 0, 1, 0, 1);
        step(1, 2'b01, 8, 0, 0, 0, 0, 0, 0, 1);
        step(1, 2'b01, 8, 0, 0, 0, 0, 0, 0, 1);
        // reset with all stages valid, then flush
        repeat (3) step(1, 2'b00, 0, 0, 1, 9, 0, 0, 0, 1);
        step(1, 2'b11, 9, 9, 0, 0, 0, 0, 0, 0);
        step(1, 2'b11, 9, 9, 0, 0, 0, 0, 0, 1);
        step(1, 2'b00, 0, 0, 1, 10, 0, 0, 1, 1);
        step(1, 2'b01, 10, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3000; i++) begin
            if (!(last_stall && $urandom_range(0, 9) < 7)) begin
                r_v = $urandom_range(0, 9) < 8; r_en = 2'($urandom);
                r_rs0 = 5'($urandom_range(0, 3)); r_rs1 = 5'($urandom_range(0, 3));
                r_we = $urandom_range(0, 3) != 0; r_wr = 5'($urandom_range(0, 3));
                r_lat = $urandom_range(0, 3);
            end
            r_hold = $urandom_range(0, 4) == 0; r_fl = $urandom_range(0, 9) == 0;
            r_rst = $urandom_range(0, 49) != 0;
            step(r_v, r_en, r_rs0, r_rs1, r_we, r_wr, r_lat, r_hold, r_fl, r_rst);
        end
        step(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1);
        step(0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1);
        repeat (3) @(posedge cpu_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
`ifdef HAZ_PERF_CNT_EN
        checks += 2;
        if (perf_stall_cnt !== 32'(ps_m)) begin
            errors++;
            $display("FAIL perf_stall_cnt got=%0d exp=%0d", perf_stall_cnt, ps_m);
        end
        if (perf_fwd_cnt !== 32'(pf_m)) begin
            errors++;
            $display("FAIL perf_fwd_cnt got=%0d exp=%0d", perf_fwd_cnt, pf_m);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
